// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory image loader.
package imem_pkg;

  localparam int unsigned IMEM_WORDS = 65536;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    RUN,
    RECV,
    WRITE,
    RELEASE
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles four streamed bytes into one little-endian 32-bit word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      asm_q    <= '0;
    end else if (push) begin
      asm_q[{byte_cnt, 3'b000} +: 8] <= din;
      byte_cnt                       <= byte_cnt + 2'd1;
    end
  end

  // full means three bytes are held, so the next push completes the word
  assign full = (byte_cnt == 2'd3);
  assign word = asm_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory while holding the core in reset;
// in RUN the memory address port follows the core fetch address.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = imem_pkg::IMEM_WORDS,
  parameter int unsigned CNT_W      = imem_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, nstate;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_idx;
  logic             err_q;
  logic             count_ok;
  logic             start_ok;
  logic             push;
  logic             full;
  logic [31:0]      word;

  // the depth guard only bites when IMEM_WORDS is smaller than 2^CNT_W
  assign count_ok = (word_count != '0) && (32'(word_count) < IMEM_WORDS);
  assign start_ok = (state == RUN) && start && count_ok;
  assign push     = (state == RECV) && byte_valid;

  byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .push (push),
    .din  (byte_data),
    .word (word),
    .full (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      RUN:     if (start_ok) nstate = RECV;
      RECV:    if (push && full) nstate = WRITE;
      WRITE:   nstate = (word_idx == count_q - CNT_W'(1)) ? RELEASE : RECV;
      RELEASE: nstate = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      word_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == RUN && start) begin
        if (count_ok) begin
          count_q  <= word_count;
          word_idx <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state == WRITE && nstate == RECV) word_idx <= word_idx + CNT_W'(1);
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = 32'({word_idx, 2'b00});
    core_rst   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      RUN: begin
        mem_addr = fetch_addr;
        core_rst = 1'b0;
        busy     = 1'b0;
      end
      RECV:    byte_ready = 1'b1;
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = word;
      end
      RELEASE: done = 1'b1;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads checked against a word/address model of the image.
module tb_imem_loader;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [31:0]      fetch_addr;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic             core_rst;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [64];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  imem_loader #(.IMEM_WORDS(65536), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, ".mem_we"},     32'(mem_we),     32'd0);
    check({tag, ".mem_wdata"},  mem_wdata,       32'd0);
    check({tag, ".core_rst"},   32'(core_rst),   32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
    check({tag, ".mem_addr"},   mem_addr,        fetch_addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // gap_mode: 0 none, 1 exactly three idle cycles between bytes, 2 random 0..2
  task automatic run_load(input string tag, input int n, input int gap_mode,
                          input int start_at, input int abort_at);
    int idx = 0;
    int gap_left = 0;
    int dones = 0;
    bit seen_done = 0;
    bit aborted = 0;
    bit pulsed = 0;
    bit accept;
    int exp_writes;
    logic [31:0] exp_word;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    word_count = CNT_W'(n);
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end else if (mem_wdata !== 32'd0) begin
        check({tag, ".wdata_idle"}, mem_wdata, 32'd0);
      end
      if (done) begin
        dones++;
        seen_done = 1;
        check({tag, ".core_rst_release"}, 32'(core_rst), 32'd1);
        break;
      end
      if (busy !== 1'b1 || core_rst !== 1'b1)
        check({tag, ".core_rst_busy_load"}, {30'd0, busy, core_rst}, 32'd3);
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        byte_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_idle({tag, ".after_rst"});
        check({tag, ".err_after_rst"}, 32'(err), 32'd0);
        aborted = 1;
        break;
      end
      if (start_at >= 0 && idx == start_at && !pulsed) begin
        start = 1'b1;
        word_count = '0;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (gap_left > 0 || idx >= 4 * n) begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        if (gap_left > 0) gap_left--;
      end else begin
        byte_valid = 1'b1;
        byte_data = img[idx];
      end
      accept = byte_valid && byte_ready;
      tick();
      if (accept) begin
        idx++;
        gap_left = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;
    if (!aborted) begin
      check({tag, ".done_seen"}, 32'(seen_done), 32'd1);
      tick();
      check_idle({tag, ".post"});
    end
    exp_writes = aborted ? abort_at / 4 : n;
    check({tag, ".write_count"}, 32'(wr_addr.size()), 32'(exp_writes));
    check({tag, ".done_count"}, 32'(dones), aborted ? 32'd0 : 32'd1);
    for (int w = 0; w < exp_writes && w < wr_addr.size(); w++) begin
      exp_word = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
      check($sformatf("%s.addr%0d", tag, w), wr_addr[w], 32'(4 * w));
      check($sformatf("%s.data%0d", tag, w), wr_data[w], exp_word);
    end
  endtask

  initial begin
    logic [7:0] prog [8];
    int n;
    rst = 1'b0;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    fetch_addr = 32'h0000_0090;
    #1;
    do_reset();
    check_idle("reset");
    check("reset.err", 32'(err), 32'd0);

    for (int i = 0; i < 4; i++) begin
      check_idle("idle90");
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      fetch_addr = $urandom;
      #1;
      check_idle("idle_rand");
      tick();
    end

    prog = '{8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
    for (int i = 0; i < 8; i++) img[i] = prog[i];
    run_load("two_word", 2, 0, -1, -1);
    run_load("backpressure", 2, 1, -1, -1);

    start = 1'b1;
    word_count = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("zero.err", 32'(err), 32'd1);
      check_idle("zero");
      tick();
    end
    do_reset();
    check("zero.err_cleared", 32'(err), 32'd0);

    run_load("start_ignored", 2, 0, 2, -1);
    check("start_ignored.err", 32'(err), 32'd0);

    run_load("abort", 2, 0, -1, 6);

    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < 4 * n; i++) img[i] = 8'($urandom);
      fetch_addr = $urandom;
      run_load($sformatf("rand%0d", t), n, 2, -1, -1);
    end
    check("final.err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: IMEM_WORDS, default 65536, instruction memory depth in 32-bit words.
REQ-002 Parameter: CNT_W, default 16, width of word counters, equal to log2(IMEM_WORDS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins an image load.
REQ-006 word_count  input  CNT_W  number of words to load; latched on an accepted start.
REQ-007 byte_valid  input  1  byte source has data.
REQ-008 byte_data  input  8  image byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 fetch_addr  input  32  core PC byte address.
REQ-011 mem_addr  output  32  byte address to instruction memory; memory indexes it with bits [17:2].
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 mem_we  output  1  instruction-memory write strobe.
REQ-014 core_rst  output  1  holds the core in reset while an image loads.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse when a load completes.
REQ-017 err  output  1  sticky flag; cleared only by rst.

Function
REQ-018 States SHALL be RUN, RECV, WRITE and RELEASE.
REQ-019 RUN: mem_addr = fetch_addr combinationally; mem_we=0; byte_ready=0; core_rst=0; busy=0.
REQ-020 RUN with start=1 and word_count!=0 SHALL latch word_count, clear word_idx and byte_cnt, and go to RECV.
REQ-021 RUN with start=1 and word_count=0 SHALL set err and stay in RUN.
REQ-022 RECV: byte_ready=1; a byte is accepted when byte_valid && byte_ready.
REQ-023 Accepted bytes SHALL pack little-endian: byte_cnt 0 goes to bits [7:0] and byte_cnt 3 goes to bits [31:24].
REQ-024 Acceptance of the 4th byte (byte_cnt=3) SHALL move RECV to WRITE next cycle, with byte_cnt returning to 0.
REQ-025 byte_valid=0 in RECV SHALL hold all state; there is no timeout.
REQ-026 WRITE lasts exactly one cycle: mem_we=1, mem_addr={word_idx,2'b00} zero-extended to 32 bits, mem_wdata=assembled word, byte_ready=0.
REQ-027 WRITE with word_idx = latched count-1 SHALL go to RELEASE; otherwise word_idx increments and the state returns to RECV.
REQ-028 RELEASE lasts exactly one cycle: done=1, core_rst still 1; next state is RUN.
REQ-029 core_rst=1 and busy=1 in RECV, WRITE and RELEASE.
REQ-030 Outside WRITE, mem_wdata = 0.
REQ-031 start SHALL be ignored in RECV, WRITE and RELEASE, with no effect on err.
REQ-032 Throughput: at most one byte per cycle; one word costs at least 5 cycles (4 RECV + 1 WRITE).
REQ-033 word_idx never exceeds count-1; there is no address wrap. Maximum load is 2^CNT_W-1 words.

Reset
REQ-034 rst SHALL force state=RUN, word_idx=0, byte_cnt=0, assembly register=0 and err=0.
REQ-035 Output values after reset: byte_ready=0, mem_we=0, mem_wdata=0, core_rst=0, busy=0, done=0, err=0, mem_addr=fetch_addr.
REQ-036 rst during a load SHALL abort it: words already written remain in memory, the partial word is discarded, and no done pulse is issued.

Structure
REQ-037 Shared package imem_pkg SHALL hold the state enum (RUN, RECV, WRITE, RELEASE), IMEM_WORDS and CNT_W.
REQ-038 One sub-module, byte_packer, SHALL hold byte_cnt and the 32-bit assembly register, with inputs clr and push and outputs word and full.
REQ-039 The FSM, counters and address mux SHALL reside in imem_loader.

Verification
REQ-040 Idle passthrough: fetch_addr=0x0000_0090 -> mem_addr=0x0000_0090, mem_we=0, core_rst=0 every cycle.
REQ-041 Two-word load: start, word_count=2; bytes 14 00 A0 E3 01 1A A0 E3 -> mem_we at mem_addr 0x0 with data 0xE3A00014, then at 0x4 with data 0xE3A01A01, then done pulse; core_rst 1->0 on the cycle after RELEASE.
REQ-042 Backpressure: same image with byte_valid low for 3 cycles between every byte -> identical writes, no duplicated or lost bytes.
REQ-043 Zero count: start with word_count=0 -> err=1, state stays RUN, core_rst=0, no writes.
REQ-044 start pulsed during RECV after 2 bytes -> ignored; load completes normally; err stays 0.
REQ-045 rst asserted after 6 bytes of a 2-word load -> exactly one write (addr 0x0) occurred; outputs take reset values next cycle; no done pulse.
